mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 104 ++++++++++
 tb/tb_mem_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master round-robin arbiter onto one memory port.
// An in-order ID FIFO steers each response back to its issuing master.
module mem_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64,
  parameter int DEPTH      = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [1:0]                     slv_req_i,
  input  logic [1:0][ADDR_WIDTH-1:0]     slv_address_i,
  input  logic [1:0]                     slv_we_i,
  input  logic [1:0][DATA_WIDTH/8-1:0]   slv_be_i,
  input  logic [1:0][DATA_WIDTH-1:0]     slv_wdata_i,
  output logic [1:0]                     slv_gnt_o,
  output logic [1:0]                     slv_rvalid_o,
  output logic [1:0][DATA_WIDTH-1:0]     slv_rdata_o,
  output logic                           mem_req_o,
  output logic [ADDR_WIDTH-1:0]          mem_address_o,
  output logic                           mem_we_o,
  output logic [DATA_WIDTH/8-1:0]        mem_be_o,
  output logic [DATA_WIDTH-1:0]          mem_wdata_o,
  input  logic                           mem_gnt_i,
  input  logic                           mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]          mem_rdata_i,
  output logic                           err_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0] id_q;
  logic [PW-1:0]    wptr_q;
  logic [PW-1:0]    rptr_q;
  logic [CW-1:0]    cnt_q;
  logic             rr_q;

  logic full;
  logic empty;
  logic sel;
  logic sel_vld;
  logic hs;
  logic pop;
  logic head;

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);

  // Sole requester wins; on contention rr_q decides.
  assign sel     = slv_req_i[1] & (~slv_req_i[0] | rr_q);
  assign sel_vld = (|slv_req_i) & ~full & ~rst_i;
  assign hs      = sel_vld & mem_gnt_i;

  always_comb begin
    mem_req_o     = 1'b0;
    mem_address_o = '0;
    mem_we_o      = 1'b0;
    mem_be_o      = '0;
    mem_wdata_o   = '0;
    if (sel_vld) begin
      mem_req_o     = 1'b1;
      mem_address_o = slv_address_i[sel];
      mem_we_o      = slv_we_i[sel];
      mem_be_o      = slv_be_i[sel];
      mem_wdata_o   = slv_wdata_i[sel];
    end
  end

  assign slv_gnt_o[0] = hs & ~sel;
  assign slv_gnt_o[1] = hs & sel;

  assign pop  = mem_rvalid_i & ~empty & ~rst_i;
  assign head = id_q[rptr_q];

  assign slv_rvalid_o[0] = pop & ~head;
  assign slv_rvalid_o[1] = pop & head;
  assign slv_rdata_o     = {2{mem_rdata_i}};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      id_q   <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      rr_q   <= 1'b0;
      err_o  <= 1'b0;
    end else begin
      if (hs) begin
        id_q[wptr_q] <= sel;
        wptr_q       <= wptr_q + 1'b1;
        rr_q         <= ~sel;
      end
      if (pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
      cnt_q <= cnt_q + CW'(hs) - CW'(pop);
      // A response with nothing outstanding is dropped and flagged.
      if (mem_rvalid_i && empty) begin
        err_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus random traffic checked
// against a queue-based reference model of the arbiter.
module tb_mem_arbiter;

  localparam int DW = 64;
  localparam int AW = 64;
  localparam int D  = 2;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [1:0]               slv_req_i;
  logic [1:0][AW-1:0]       slv_address_i;
  logic [1:0]               slv_we_i;
  logic [1:0][DW/8-1:0]     slv_be_i;
  logic [1:0][DW-1:0]       slv_wdata_i;
  logic [1:0]               slv_gnt_o;
  logic [1:0]               slv_rvalid_o;
  logic [1:0][DW-1:0]       slv_rdata_o;
  logic                     mem_req_o;
  logic [AW-1:0]            mem_address_o;
  logic                     mem_we_o;
  logic [DW/8-1:0]          mem_be_o;
  logic [DW-1:0]            mem_wdata_o;
  logic                     mem_gnt_i;
  logic                     mem_rvalid_i;
  logic [DW-1:0]            mem_rdata_i;
  logic                     err_o;

  mem_arbiter #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .DEPTH(D)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .slv_req_i(slv_req_i),
    .slv_address_i(slv_address_i),
    .slv_we_i(slv_we_i),
    .slv_be_i(slv_be_i),
    .slv_wdata_i(slv_wdata_i),
    .slv_gnt_o(slv_gnt_o),
    .slv_rvalid_o(slv_rvalid_o),
    .slv_rdata_o(slv_rdata_o),
    .mem_req_o(mem_req_o),
    .mem_address_o(mem_address_o),
    .mem_we_o(mem_we_o),
    .mem_be_o(mem_be_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  // Reference model: outstanding master IDs in issue order.
  int q[$];
  int rr_m;
  bit err_m;
  bit e_req;
  bit e_hs;
  bit e_pop;
  bit e_err;
  int e_sel;
  int hs_dut;

  task automatic chk(input string tag, input logic [199:0] got,
                     input logic [199:0] exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic sample();
    logic [1:0]   eg;
    logic [1:0]   ev;
    logic [136:0] eb;
    @(negedge clk);
    e_req = (slv_req_i != 2'b00) && (q.size() < D);
    if (slv_req_i == 2'b11) e_sel = rr_m;
    else e_sel = slv_req_i[1] ? 1 : 0;
    e_hs  = e_req && mem_gnt_i;
    e_pop = mem_rvalid_i && (q.size() > 0);
    e_err = mem_rvalid_i && (q.size() == 0);
    eg = 2'b00;
    if (e_hs) eg = (e_sel == 1) ? 2'b10 : 2'b01;
    ev = 2'b00;
    if (e_pop) ev = (q[0] == 1) ? 2'b10 : 2'b01;
    eb = '0;
    if (e_req)
      eb = {slv_address_i[e_sel], slv_we_i[e_sel],
            slv_be_i[e_sel], slv_wdata_i[e_sel]};
    if (mem_req_o && mem_gnt_i) hs_dut++;
    chk("req", mem_req_o, e_req);
    chk("gnt", slv_gnt_o, eg);
    chk("rvalid", slv_rvalid_o, ev);
    chk("err", err_o, err_m);
    chk("bus", {mem_address_o, mem_we_o, mem_be_o, mem_wdata_o}, eb);
    chk("rdata0", slv_rdata_o[0], mem_rdata_i);
    chk("rdata1", slv_rdata_o[1], mem_rdata_i);
  endtask

  task automatic adv();
    @(posedge clk);
    if (e_pop) void'(q.pop_front());
    if (e_hs) begin
      q.push_back(e_sel);
      rr_m = 1 - e_sel;
    end
    if (e_err) err_m = 1'b1;
    #1;
  endtask

  task automatic cyc();
    sample();
    adv();
  endtask

  task automatic do_reset();
    #1 rst = 1'b1;
    #1;
    chk("rst_req", mem_req_o, 1'b0);
    chk("rst_rv", slv_rvalid_o, 2'b00);
    chk("rst_err", err_o, 1'b0);
    q.delete();
    rr_m  = 0;
    err_m = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic idle();
    slv_req_i     = 2'b00;
    slv_address_i = '0;
    slv_we_i      = 2'b00;
    slv_be_i      = '0;
    slv_wdata_i   = '0;
    mem_gnt_i     = 1'b1;
    mem_rvalid_i  = 1'b0;
    mem_rdata_i   = '0;
  endtask

  initial begin
    rst = 1'b0;
    idle();
    slv_req_i    = 2'b11;
    mem_rvalid_i = 1'b1;
    do_reset();
    idle();

    // Single read from master 0.
    slv_req_i        = 2'b01;
    slv_address_i[0] = 64'h8000_0000;
    sample();
    chk("m0_gnt", slv_gnt_o, 2'b01);
    chk("m0_addr", mem_address_o, 64'h8000_0000);
    adv();
    slv_req_i    = 2'b00;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 64'hDEAD_BEEF;
    sample();
    chk("m0_rv", slv_rvalid_o, 2'b01);
    chk("m0_rdata", slv_rdata_o[0], 64'hDEAD_BEEF);
    adv();
    mem_rvalid_i = 1'b0;

    // Both masters from reset: strict alternation.
    do_reset();
    slv_req_i = 2'b11;
    for (int i = 0; i < 4; i++) begin
      mem_rvalid_i = (i > 0);
      mem_rdata_i  = {$urandom, $urandom};
      sample();
      chk("alt_gnt", slv_gnt_o, (i % 2) ? 2'b10 : 2'b01);
      if (i > 0) chk("alt_rv", slv_rvalid_o, (i % 2) ? 2'b01 : 2'b10);
      adv();
    end
    slv_req_i    = 2'b00;
    mem_rvalid_i = 1'b1;
    cyc();
    mem_rvalid_i = 1'b0;

    // FIFO full back-pressure.
    slv_req_i = 2'b01;
    hs_dut    = 0;
    for (int i = 0; i < 4; i++) begin
      sample();
      chk("fill_req", mem_req_o, i < 2);
      adv();
    end
    chk("fill_hs", hs_dut, 2);
    mem_rvalid_i = 1'b1;
    sample();
    chk("full_rv_req", mem_req_o, 1'b0);
    chk("full_rv", slv_rvalid_o, 2'b01);
    adv();
    mem_rvalid_i = 1'b0;
    sample();
    chk("refill_req", mem_req_o, 1'b1);
    adv();
    slv_req_i    = 2'b00;
    mem_rvalid_i = 1'b1;
    cyc();
    cyc();
    mem_rvalid_i = 1'b0;
    cyc();

    // Write from master 1.
    slv_req_i        = 2'b10;
    slv_address_i[1] = 64'h1000_0040;
    slv_we_i[1]      = 1'b1;
    slv_be_i[1]      = 8'hFF;
    slv_wdata_i[1]   = 64'h1122_3344_5566_7788;
    sample();
    chk("wr_gnt", slv_gnt_o, 2'b10);
    chk("wr_we", mem_we_o, 1'b1);
    chk("wr_be", mem_be_o, 8'hFF);
    chk("wr_data", mem_wdata_o, 64'h1122_3344_5566_7788);
    chk("wr_addr", mem_address_o, 64'h1000_0040);
    adv();
    slv_req_i    = 2'b00;
    mem_rvalid_i = 1'b1;
    sample();
    chk("wr_rv", slv_rvalid_o, 2'b10);
    adv();
    mem_rvalid_i = 1'b0;

    // Orphan response sets sticky error.
    mem_rvalid_i = 1'b1;
    sample();
    chk("orph_rv", slv_rvalid_o, 2'b00);
    adv();
    mem_rvalid_i = 1'b0;
    repeat (3) begin
      sample();
      chk("err_hold", err_o, 1'b1);
      adv();
    end
    do_reset();

    // Reset with two outstanding, then a stale response.
    slv_req_i = 2'b01;
    cyc();
    cyc();
    slv_req_i = 2'b11;
    do_reset();
    slv_req_i    = 2'b00;
    mem_rvalid_i = 1'b1;
    sample();
    chk("stale_rv", slv_rvalid_o, 2'b00);
    adv();
    mem_rvalid_i = 1'b0;
    sample();
    chk("stale_err", err_o, 1'b1);
    adv();
    slv_req_i = 2'b11;
    sample();
    chk("rr_reset", slv_gnt_o, 2'b01);
    adv();
    slv_req_i    = 2'b00;
    mem_rvalid_i = 1'b1;
    cyc();
    mem_rvalid_i = 1'b0;
    do_reset();

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      slv_req_i = 2'($urandom);
      slv_we_i  = 2'($urandom);
      for (int m = 0; m < 2; m++) begin
        slv_address_i[m] = {$urandom, $urandom};
        slv_be_i[m]      = 8'($urandom);
        slv_wdata_i[m]   = {$urandom, $urandom};
      end
      mem_gnt_i    = ($urandom_range(3) != 0);
      mem_rvalid_i = (q.size() > 0) && ($urandom_range(1) == 1);
      mem_rdata_i  = {$urandom, $urandom};
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
